// File: rtl/cla_serial_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cla_serial_adder: slice-serial adder, one 4-bit carry-lookahead unit/clock  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load, step;

  logic [WIDTH-1:0] a_q, b_q, s_q, s_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry, cout_q, ovf_q;

  logic [3:0] a_sl, b_sl, g, p, sum_sl;
  logic [4:0] c;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: if (START) begin
        load      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (idx == LAST_IDX) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slice select and write-back use constant part-selects so no bit can fall outside the operand.
  always_comb begin
    a_sl  = '0;
    b_sl  = '0;
    s_nxt = s_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDXW'(i)) begin
        a_sl              = a_q[4*i +: 4];
        b_sl              = b_q[4*i +: 4];
        s_nxt[4*i +: 4]   = sum_sl;
      end
    end
  end

  assign g = a_sl & b_sl;
  assign p = a_sl | b_sl;

  // Every carry is a flat sum of products from c0; nothing ripples inside the slice.
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_sl = a_sl ^ b_sl ^ c[3:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      a_q    <= A;
      b_q    <= B;
      s_q    <= '0;
      idx    <= '0;
      carry  <= Cin;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (step) begin
      s_q   <= s_nxt;
      carry <= c[4];
      if (idx == LAST_IDX) begin
        cout_q <= c[4];
        ovf_q  <= c[3] ^ c[4];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign OVF  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// Self-checking bench for cla_serial_adder at WIDTH=16 and WIDTH=4 against {Cout,S}=A+B+Cin.
module tb_cla_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, s4;

  int checks = 0;
  int errors = 0;

  cla_serial_adder #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .START(start16), .A(a16), .B(b16), .Cin(cin16),
    .BUSY(busy16), .DONE(done16), .S(s16), .Cout(cout16), .OVF(ovf16)
  );

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .A(a4), .B(b4), .Cin(cin4),
    .BUSY(busy4), .DONE(done4), .S(s4), .Cout(cout4), .OVF(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} for a w-bit addition using plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [31:0] sum;
    logic [15:0] s;
    logic        co, ov;
    sum = 32'(a) + 32'(b) + 32'(ci);
    s   = 16'(sum & ((32'd1 << w) - 32'd1));
    co  = sum[w];
    ov  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic sel_done(input bit w4);
    return w4 ? done4 : done16;
  endfunction

  function automatic logic sel_busy(input bit w4);
    return w4 ? busy4 : busy16;
  endfunction

  // Issue one operation, wait for DONE (bounded), check result, then check DONE drops.
  task automatic check_op(input string tag, input bit w4, input logic [15:0] a_in,
                          input logic [15:0] b_in, input logic ci, input bit hold);
    logic [15:0] a, b;
    logic [17:0] exp;
    int          lat, busy_n, w;
    w = w4 ? 4 : 16;
    a = w4 ? (a_in & 16'h000f) : a_in;
    b = w4 ? (b_in & 16'h000f) : b_in;
    exp = model(w, a, b, ci);
    @(negedge clk);
    if (w4) begin a4 = a[3:0]; b4 = b[3:0]; cin4 = ci; start4 = 1'b1; end
    else    begin a16 = a; b16 = b; cin16 = ci; start16 = 1'b1; end
    @(negedge clk);
    lat    = 1;
    busy_n = int'(sel_busy(w4));
    if (hold) begin
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = ~ci;
    end else begin
      start16 = 1'b0;
      start4  = 1'b0;
    end
    while (!sel_done(w4) && lat < 20) begin
      @(negedge clk);
      lat++;
      busy_n += int'(sel_busy(w4));
    end
    chk({tag, "_latency"}, 32'(lat), 32'(w / 4 + 1));
    if (w4) begin
      chk({tag, "_s"},    32'(s4),    32'(exp[3:0]));
      chk({tag, "_cout"}, 32'(cout4), 32'(exp[16]));
      chk({tag, "_ovf"},  32'(ovf4),  32'(exp[17]));
    end else begin
      chk({tag, "_s"},    32'(s16),    32'(exp[15:0]));
      chk({tag, "_cout"}, 32'(cout16), 32'(exp[16]));
      chk({tag, "_ovf"},  32'(ovf16),  32'(exp[17]));
    end
    if (hold) chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd5);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(sel_done(w4)), 32'd0);
    chk({tag, "_busy_fall"},  32'(sel_busy(w4)), 32'd0);
    start16 = 1'b0;
    start4  = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    int          done_seen;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s16",    32'(s16),    32'd0);
    chk("rst_cout16", 32'(cout16), 32'd0);
    chk("rst_ovf16",  32'(ovf16),  32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_s4",     32'(s4),     32'd0);
    chk("rst_busy4",  32'(busy4),  32'd0);
    rst = 1'b0;

    check_op("wrap",     1'b0, 16'h0001, 16'hffff, 1'b0, 1'b0);
    check_op("posovf",   1'b0, 16'h7fff, 16'h0001, 1'b0, 1'b0);
    check_op("negovf",   1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_s",    32'(s16),    32'h0000);
    chk("hold_cout", 32'(cout16), 32'd1);
    chk("hold_ovf",  32'(ovf16),  32'd1);
    check_op("slice_carry", 1'b0, 16'h00ff, 16'h0000, 1'b1, 1'b0);
    check_op("start_held",  1'b0, 16'h1234, 16'h4321, 1'b1, 1'b1);

    // Reset after slice 1 has been processed.
    @(negedge clk);
    a16 = 16'hffff; b16 = 16'h0001; cin16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_s",    32'(s16),    32'd0);
    chk("midrst_cout", 32'(cout16), 32'd0);
    chk("midrst_ovf",  32'(ovf16),  32'd0);
    chk("midrst_busy", 32'(busy16), 32'd0);
    done_seen = 0;
    repeat (6) begin
      done_seen += int'(done16);
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    check_op("after_rst", 1'b0, 16'hffff, 16'h0001, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      check_op("rand16", 1'b0, ra, rb, rc, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      check_op("rand4", 1'b1, ra, rb, rc, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
